// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I datapath constants and the ALU operation encoding.
// alu_op_t is four bits wide, so undefined codes still fit and can travel through the pipeline.
package riscv_32i_defs_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_t;

endpackage

// File: rtl/alu_issue_intf.sv
// Bundle of issue-stage signals for bind-style checkers and coverage collectors.
// Monitors see the signals through read-only modports; the properties restate the handshake rules.
interface alu_issue_intf
  import riscv_32i_defs_pkg::*;
#(
  parameter int XLEN   = riscv_32i_defs_pkg::XLEN,
  parameter int REG_AW = riscv_32i_defs_pkg::REG_AW
) (
  input logic clk,
  input logic rst
);

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  alu_op_t           alu_op;
  logic [XLEN-1:0]   in_a;
  logic [XLEN-1:0]   in_b;
  logic [REG_AW-1:0] rd_addr;

  modport assertion (
    input clk, rst, in_valid, in_ready, flush, out_valid, out_ready,
          alu_op, in_a, in_b, rd_addr
  );

  modport coverage (
    input clk, rst, in_valid, in_ready, flush, out_valid, out_ready,
          alu_op, in_a, in_b, rd_addr
  );

  a_ready_eq : assert property (@(posedge clk) disable iff (rst)
    in_ready == ((!out_valid || out_ready) && !flush));

  // A stalled operation keeps its identity until it is consumed or flushed.
  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(alu_op) && $stable(rd_addr)));

  a_flush_empties : assert property (@(posedge clk) disable iff (rst)
    flush |=> !out_valid);

  c_accept_while_draining : cover property (@(posedge clk) disable iff (rst)
    in_valid && in_ready && out_valid && out_ready);

endinterface

// File: rtl/operand_fwd_mux.sv
// Picks one operand from the EX/MEM bus, the MEM/WB bus or a base value, younger bus first.
// Index 0 never matches a bus, so x0 always comes from the base value.
module operand_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   base_data_i,
  input  logic              ex_we_i,
  input  logic [REG_AW-1:0] ex_addr_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);

  logic nz;

  assign nz = (addr_i != '0);

  always_comb begin
    data_o = base_data_i;
    if (nz && ex_we_i && (ex_addr_i == addr_i)) begin
      data_o = ex_data_i;
    end else if (nz && wb_we_i && (wb_addr_i == addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry valid/ready register slice in front of the ALU that captures forwarded operands and keeps
// refreshing a stalled operation's operands from the result buses until it is consumed.
module alu_issue_stage
  import riscv_32i_defs_pkg::*;
#(
  parameter int XLEN   = riscv_32i_defs_pkg::XLEN,
  parameter int REG_AW = riscv_32i_defs_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_t           in_alu_op,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              fwd_ex_we,
  input  logic [REG_AW-1:0] fwd_ex_addr,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic              fwd_wb_we,
  input  logic [REG_AW-1:0] fwd_wb_addr,
  input  logic [XLEN-1:0]   fwd_wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output alu_op_t           alu_op,
  output logic [XLEN-1:0]   in_a,
  output logic [XLEN-1:0]   in_b,
  output logic [REG_AW-1:0] rd_addr
);

  logic              valid_q, valid_d;
  alu_op_t           op_q;
  logic [XLEN-1:0]   a_q, b_q, a_d, b_d;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic              use_imm_q;
  logic              accept, hold;
  logic [REG_AW-1:0] a_addr, b_addr;
  logic [XLEN-1:0]   a_base, b_base, a_fwd, b_fwd;

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign hold     = valid_q && !out_ready;

  // The same muxes serve capture (incoming indices/data) and refresh (held indices/operands).
  assign a_addr = accept ? in_rs1_addr : rs1_q;
  assign b_addr = accept ? in_rs2_addr : rs2_q;
  assign a_base = accept ? in_rs1_data : a_q;
  assign b_base = accept ? in_rs2_data : b_q;

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux_a (
    .addr_i(a_addr), .base_data_i(a_base),
    .ex_we_i(fwd_ex_we), .ex_addr_i(fwd_ex_addr), .ex_data_i(fwd_ex_data),
    .wb_we_i(fwd_wb_we), .wb_addr_i(fwd_wb_addr), .wb_data_i(fwd_wb_data),
    .data_o(a_fwd)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux_b (
    .addr_i(b_addr), .base_data_i(b_base),
    .ex_we_i(fwd_ex_we), .ex_addr_i(fwd_ex_addr), .ex_data_i(fwd_ex_data),
    .wb_we_i(fwd_wb_we), .wb_addr_i(fwd_wb_addr), .wb_data_i(fwd_wb_data),
    .data_o(b_fwd)
  );

  always_comb begin
    a_d = a_fwd;
    if (accept) begin
      b_d = in_use_imm ? in_imm : b_fwd;
    end else begin
      b_d = use_imm_q ? b_q : b_fwd;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_q      <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        op_q      <= in_alu_op;
        a_q       <= a_d;
        b_q       <= b_d;
        rd_q      <= in_rd_addr;
        rs1_q     <= in_rs1_addr;
        rs2_q     <= in_rs2_addr;
        use_imm_q <= in_use_imm;
      end else if (hold) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = op_q;
  assign in_a      = a_q;
  assign in_b      = b_q;
  assign rd_addr   = rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: inputs change on the falling edge, outputs are compared a half cycle
// after the rising edge (or 1ns after a drive for combinational ready).
module tb_alu_issue_stage;
  import riscv_32i_defs_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready;
  alu_op_t     in_alu_op;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic        fwd_ex_we, fwd_wb_we;
  logic [4:0]  fwd_ex_addr, fwd_wb_addr;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        flush, out_valid, out_ready;
  alu_op_t     alu_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  rd_addr;

  int errors = 0;
  int checks = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_addr(fwd_wb_addr), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .in_a(in_a), .in_b(in_b), .rd_addr(rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    in_valid = 0; in_alu_op = ALU_ADD; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
    fwd_ex_we = 0; fwd_ex_addr = 0; fwd_ex_data = 0;
    fwd_wb_we = 0; fwd_wb_addr = 0; fwd_wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic drive_op(input alu_op_t op, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
    in_valid = 1; in_alu_op = op; in_rs1_addr = rs1; in_rs1_data = d1;
    in_rs2_addr = rs2; in_rs2_data = d2; in_imm = imm; in_use_imm = use_imm; in_rd_addr = rd;
  endtask

  task automatic test_reset();
    idle(); rst = 1; in_valid = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({alu_op, in_a, in_b, rd_addr} !== '0) begin errors++; $display("FAIL reset_data op=%h a=%h b=%h rd=%h exp=0", alu_op, in_a, in_b, rd_addr); end
    rst = 0; idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_forward_priority();
    drive_op(ALU_ADD, 5'd5, 32'h10, 5'd2, 32'h22, 0, 0, 5'd7);
    fwd_ex_we = 1; fwd_ex_addr = 5; fwd_ex_data = 32'hAA;
    fwd_wb_we = 1; fwd_wb_addr = 5; fwd_wb_data = 32'hBB;
    @(negedge clk);
    checks++; if (in_a !== 32'hAA) begin errors++; $display("FAIL fwd_ex_over_wb got=%h exp=000000aa", in_a); end
    checks++; if (in_b !== 32'h22) begin errors++; $display("FAIL fwd_no_match_b got=%h exp=00000022", in_b); end
    checks++; if (out_valid !== 1'b1 || rd_addr !== 5'd7) begin errors++; $display("FAIL fwd_valid_rd valid=%b rd=%0d exp 1/7", out_valid, rd_addr); end
    drive_op(ALU_SUB, 5'd6, 32'h20, 5'd6, 32'h20, 0, 0, 5'd8);
    fwd_ex_we = 1; fwd_ex_addr = 7; fwd_ex_data = 32'hDD;
    fwd_wb_we = 1; fwd_wb_addr = 6; fwd_wb_data = 32'hCC;
    @(negedge clk);
    checks++; if (in_a !== 32'hCC || in_b !== 32'hCC) begin errors++; $display("FAIL fwd_wb_only a=%h b=%h exp=cc/cc", in_a, in_b); end
    checks++; if (alu_op !== ALU_SUB) begin errors++; $display("FAIL fwd_op got=%h exp=1", alu_op); end
    idle(); @(negedge clk);
  endtask

  task automatic test_x0();
    drive_op(ALU_OR, 5'd0, 32'h0, 5'd0, 32'h5, 0, 0, 5'd1);
    fwd_ex_we = 1; fwd_ex_addr = 0; fwd_ex_data = 32'hFFFF;
    fwd_wb_we = 1; fwd_wb_addr = 0; fwd_wb_data = 32'h9999;
    @(negedge clk);
    checks++; if (in_a !== 32'h0) begin errors++; $display("FAIL x0_a got=%h exp=00000000", in_a); end
    checks++; if (in_b !== 32'h5) begin errors++; $display("FAIL x0_b got=%h exp=00000005", in_b); end
    idle(); @(negedge clk);
  endtask

  task automatic test_imm_and_invalid_op();
    drive_op(alu_op_t'(4'hF), 5'd3, 32'h3, 5'd4, 32'h4, 32'hFFFFFFF0, 1, 5'd31);
    fwd_ex_we = 1; fwd_ex_addr = 4; fwd_ex_data = 32'h4444;
    @(negedge clk);
    checks++; if (in_b !== 32'hFFFFFFF0) begin errors++; $display("FAIL imm_b got=%h exp=fffffff0", in_b); end
    checks++; if (alu_op !== alu_op_t'(4'hF)) begin errors++; $display("FAIL invalid_op got=%h exp=f", alu_op); end
    checks++; if (in_a !== 32'h3 || rd_addr !== 5'd31) begin errors++; $display("FAIL imm_a_rd a=%h rd=%0d exp 3/31", in_a, rd_addr); end
    idle(); @(negedge clk);
  endtask

  task automatic test_hold_refresh();
    drive_op(ALU_SUB, 5'd1, 32'h11, 5'd3, 32'h1, 0, 0, 5'd9);
    out_ready = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_b !== 32'h1) begin errors++; $display("FAIL hold_capture valid=%b b=%h exp 1/1", out_valid, in_b); end
    drive_op(ALU_XOR, 5'd2, 32'h77, 5'd2, 32'h77, 0, 0, 5'd2);
    fwd_wb_we = 1; fwd_wb_addr = 3; fwd_wb_data = 32'h1234;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (in_b !== 32'h1234) begin errors++; $display("FAIL hold_wb_b got=%h exp=00001234", in_b); end
    checks++; if (alu_op !== ALU_SUB || rd_addr !== 5'd9 || out_valid !== 1'b1) begin errors++; $display("FAIL hold_stable op=%h rd=%0d valid=%b exp 1/9/1", alu_op, rd_addr, out_valid); end
    checks++; if (in_a !== 32'h11) begin errors++; $display("FAIL hold_a got=%h exp=00000011", in_a); end
    in_valid = 0; fwd_wb_we = 0;
    fwd_ex_we = 1; fwd_ex_addr = 1; fwd_ex_data = 32'hE1;
    fwd_wb_we = 1; fwd_wb_addr = 1; fwd_wb_data = 32'hB1;
    @(negedge clk);
    checks++; if (in_a !== 32'hE1 || in_b !== 32'h1234) begin errors++; $display("FAIL hold_ex_a a=%h b=%h exp e1/1234", in_a, in_b); end
    idle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drive_op(ALU_AND, 5'd10, 32'hA0, 5'd11, 32'hB0, 0, 0, 5'd12);
    @(negedge clk);
    checks++; if (in_a !== 32'hA0 || alu_op !== ALU_AND) begin errors++; $display("FAIL b2b_first a=%h op=%h exp a0/9", in_a, alu_op); end
    drive_op(ALU_SLL, 5'd13, 32'hC0, 5'd14, 32'hD0, 0, 0, 5'd15);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (in_b !== 32'hD0 || rd_addr !== 5'd15 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second b=%h rd=%0d valid=%b exp d0/15/1", in_b, rd_addr, out_valid); end
    idle(); @(negedge clk);
  endtask

  task automatic test_flush();
    drive_op(ALU_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 0, 0, 5'd3);
    out_ready = 0;
    @(negedge clk);
    flush = 1; out_ready = 1;
    drive_op(ALU_SRA, 5'd4, 32'h4, 5'd5, 32'h5, 0, 0, 5'd6);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    idle(); @(negedge clk);
  endtask

  task automatic test_async_reset();
    drive_op(ALU_OR, 5'd8, 32'h55, 5'd9, 32'h66, 0, 0, 5'd4);
    out_ready = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0 || {alu_op, in_a, in_b, rd_addr} !== '0) begin errors++; $display("FAIL async_rst valid=%b op=%h a=%h b=%h rd=%h exp all 0", out_valid, alu_op, in_a, in_b, rd_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_accept_ignored got=%b exp=0", out_valid); end
    rst = 0; idle();
    drive_op(ALU_AND, 5'd7, 32'h7, 5'd0, 32'h0, 0, 0, 5'd2);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_a !== 32'h7 || alu_op !== ALU_AND) begin errors++; $display("FAIL post_rst_accept valid=%b a=%h op=%h exp 1/7/9", out_valid, in_a, alu_op); end
    idle(); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_x0();
    test_imm_and_invalid_op();
    test_hold_refresh();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
- REQ-001 Parameters: XLEN, 32, data width. REG_AW, 5, register address width.
- REQ-002 clk  in  1  single clock; all state updates on rising edge.
- REQ-003 rst  in  1  asynchronous, active-high reset.
- REQ-004 in_valid  in  1  decode stage presents an operation.
- REQ-005 in_ready  out  1  stage accepts the operation this cycle.
- REQ-006 in_alu_op  in  alu_op_t  operation code from riscv_32i_defs_pkg.
- REQ-007 in_rs1_addr, in_rs2_addr  in  REG_AW  source register indices.
- REQ-008 in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- REQ-009 in_imm  in  XLEN  sign-extended immediate.
- REQ-010 in_use_imm  in  1  selects in_imm instead of rs2 as operand B.
- REQ-011 in_rd_addr  in  REG_AW  destination index, passed through.
- REQ-012 fwd_ex_we, fwd_ex_addr, fwd_ex_data  in  1/REG_AW/XLEN  EX/MEM result bus (younger).
- REQ-013 fwd_wb_we, fwd_wb_addr, fwd_wb_data  in  1/REG_AW/XLEN  MEM/WB result bus (older).
- REQ-014 flush  in  1  discard held and incoming operation.
- REQ-015 out_valid  out  1  operation present toward ALU.
- REQ-016 out_ready  in  1  downstream consumes this cycle.
- REQ-017 alu_op, in_a, in_b, rd_addr  out  alu_op_t/XLEN/XLEN/REG_AW  registered ALU operands.

Function
- REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
- REQ-019 Accept (in_valid && in_ready) SHALL load all output registers and set out_valid on the next edge; latency 1 cycle.
- REQ-020 out_ready && out_valid with no accept SHALL clear out_valid next edge.
- REQ-021 out_valid && !out_ready SHALL hold alu_op, rd_addr, and out_valid stable.
- REQ-022 Operand A at capture SHALL be: fwd_ex_data if fwd_ex_we and fwd_ex_addr==rs1; else fwd_wb_data if fwd_wb_we and fwd_wb_addr==rs1; else in_rs1_data.
- REQ-023 Operand B at capture SHALL be in_imm when in_use_imm, else rs2 resolved by the REQ-022 priority.
- REQ-024 Register index 0 SHALL never match a forward bus; x0 operand SHALL come from read data.
- REQ-025 While holding (REQ-021), each cycle a forward bus write to the held rs1 (or rs2 when !use_imm) SHALL update in_a (in_b), EX over WB priority; stage stores rs1/rs2 indices and use_imm for this.
- REQ-026 flush SHALL clear out_valid next edge, override simultaneous accept and out_ready, and leave data registers don't-care.
- REQ-027 Invalid alu_op codes (e.g. 4'b1111) SHALL pass through unmodified.
- REQ-028 No arithmetic performed; widths exact, no truncation or extension.

Reset
- REQ-029 rst SHALL asynchronously force out_valid=0, alu_op=0, in_a=0, in_b=0, rd_addr=0 and all held indices to 0.
- REQ-030 During rst in_ready SHALL still follow REQ-018 (1); accepts while rst is asserted are ignored.
- REQ-031 Reset deassertion mid-stream SHALL yield an empty stage; first accept afterward behaves per REQ-019.

Structure
- REQ-032 alu_op_t and XLEN/REG_AW constants SHALL come from riscv_32i_defs_pkg; no new types defined locally.
- REQ-033 One sub-module, operand_fwd_mux (one combinational priority select per operand, instantiated twice), SHALL be used.
- REQ-034 A companion interface alu_issue_intf with assertion and coverage modports SHALL be provided.

Verification
- REQ-035 rs1=5 data 0x10, fwd_ex we addr5 data 0xAA, fwd_wb we addr5 data 0xBB -> in_a=0xAA one cycle later.
- REQ-036 rs1=0 data 0, fwd_ex we addr0 data 0xFFFF -> in_a=0.
- REQ-037 use_imm=1 imm=0xFFFFFFF0, fwd_ex matching rs2 -> in_b=0xFFFFFFF0.
- REQ-038 Hold with out_ready=0, then fwd_wb writes held rs2 with 0x1234 -> in_b=0x1234, alu_op unchanged, out_valid=1.
- REQ-039 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, in_ready=0 that cycle.
- REQ-040 rst asserted between edges while out_valid=1 -> all outputs 0 immediately, no clock required.
